// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/LS memory arbiter.
package mem_arb_pkg;

  // Byte-address bits below the word index.
  localparam int unsigned ADDR_LSB   = 2;
  // Structs are sized for the widest supported data bus.
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic {
    LS_PRIO,
    IF_PRIO
  } arb_state_t;

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
    logic                  err;
  } mem_rsp_t;

  // Word-aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
    return (addr[ADDR_LSB-1:0] == '0) && (addr < (words << ADDR_LSB));
  endfunction

endpackage

// File: rtl/mem_arb_rsp_reg.sv
// Per-port response register: captures data/err on acceptance, one-cycle valid pulse.
module mem_arb_rsp_reg
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_en,
  input  mem_rsp_t              rsp_in,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  mem_rsp_t q;

  // Valid follows acceptance each cycle; data/err hold until the next response.
  always_ff @(posedge clk) begin
    if (rst_en) begin
      q <= '0;
    end else begin
      q.valid <= rsp_in.valid;
      if (rsp_in.valid) begin
        q.data <= rsp_in.data;
        q.err  <= rsp_in.err;
      end
    end
  end

  // A pulse pending when reset rises is suppressed so it is never seen.
  assign rsp_valid = q.valid && !rst_en;
  assign rsp_data  = DATA_WIDTH'(q.data);
  assign rsp_err   = q.err;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and LS onto one single-port memory with registered responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORDS      = 64,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_en,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [31:0]           ls_req_addr,
  input  logic                  ls_req_we,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rsp_data,
  output logic                  ls_rsp_err,
  output logic                  mem_write_enable,
  output logic [31:0]           mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  arb_state_t            state;
  logic [3:0]            wait_cnt;
  logic [3:0]            wait_nxt;
  logic                  if_win;
  logic                  ls_win;
  logic                  gnt_legal;
  logic [MEM_DATA_W-1:0] rd_data;
  mem_req_t              gnt;
  mem_rsp_t              if_rsp_nxt;
  mem_rsp_t              ls_rsp_nxt;

  // Grant: LS by default, IF when alone or when the priority state favours it.
  always_comb begin
    if_win       = if_req_valid && (!ls_req_valid || state == IF_PRIO);
    ls_win       = ls_req_valid && !if_win;
    if_req_ready = if_win && !rst_en;
    ls_req_ready = ls_win && !rst_en;
  end

  // Granted request drives the memory; illegal writes never assert write enable.
  always_comb begin
    gnt = '0;
    if (if_req_ready) begin
      gnt.addr  = if_req_addr;
      gnt.wdata = MEM_DATA_W'(ls_req_wdata);
    end else if (ls_req_ready) begin
      gnt.addr  = ls_req_addr;
      gnt.we    = ls_req_we;
      gnt.wdata = MEM_DATA_W'(ls_req_wdata);
    end
    gnt_legal        = addr_legal(gnt.addr, WORDS);
    mem_address      = gnt.addr;
    mem_write_enable = gnt.we && gnt_legal;
    mem_write_data   = DATA_WIDTH'(gnt.wdata);
  end

  // Response contents: read data for legal reads, zero for writes and errors.
  always_comb begin
    rd_data          = (gnt_legal && !gnt.we) ? MEM_DATA_W'(mem_read_data) : '0;
    if_rsp_nxt       = '0;
    if_rsp_nxt.valid = if_req_ready;
    if_rsp_nxt.data  = rd_data;
    if_rsp_nxt.err   = !gnt_legal;
    ls_rsp_nxt       = '0;
    ls_rsp_nxt.valid = ls_req_ready;
    ls_rsp_nxt.data  = rd_data;
    ls_rsp_nxt.err   = !gnt_legal;
  end

  // IF stall counter: counts refused IF cycles, saturating at MAX_WAIT.
  always_comb begin
    if (!if_req_valid || if_req_ready) begin
      wait_nxt = '0;
    end else if (wait_cnt < 4'(MAX_WAIT)) begin
      wait_nxt = wait_cnt + 4'd1;
    end else begin
      wait_nxt = wait_cnt;
    end
  end

  // Priority FSM: IF_PRIO is entered together with the counter reaching
  // MAX_WAIT, so IF wins on the cycle right after the MAX_WAIT-th stall.
  always_ff @(posedge clk) begin
    if (rst_en) begin
      state    <= LS_PRIO;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      if (if_req_ready) begin
        state <= LS_PRIO;
      end else if (wait_nxt == 4'(MAX_WAIT)) begin
        state <= IF_PRIO;
      end
    end
  end

  mem_arb_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_if_rsp (
    .clk       (clk),
    .rst_en    (rst_en),
    .rsp_in    (if_rsp_nxt),
    .rsp_valid (if_rsp_valid),
    .rsp_data  (if_rsp_data),
    .rsp_err   (if_rsp_err)
  );

  mem_arb_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ls_rsp (
    .clk       (clk),
    .rst_en    (rst_en),
    .rsp_in    (ls_rsp_nxt),
    .rsp_valid (ls_rsp_valid),
    .rsp_data  (ls_rsp_data),
    .rsp_err   (ls_rsp_err)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural word memory attached.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_en;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic [31:0] ls_req_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        ls_rsp_err;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [64];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  exp_t if_e;
  exp_t ls_e;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  mem_arbiter #(.DATA_WIDTH(32), .WORDS(64), .MAX_WAIT(4)) dut (
    .clk              (clk),
    .rst_en           (rst_en),
    .if_req_valid     (if_req_valid),
    .if_req_ready     (if_req_ready),
    .if_req_addr      (if_req_addr),
    .if_rsp_valid     (if_rsp_valid),
    .if_rsp_data      (if_rsp_data),
    .if_rsp_err       (if_rsp_err),
    .ls_req_valid     (ls_req_valid),
    .ls_req_ready     (ls_req_ready),
    .ls_req_addr      (ls_req_addr),
    .ls_req_we        (ls_req_we),
    .ls_req_wdata     (ls_req_wdata),
    .ls_rsp_valid     (ls_rsp_valid),
    .ls_rsp_data      (ls_rsp_data),
    .ls_rsp_err       (ls_rsp_err),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Single-port memory: synchronous write, combinational read.
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[7:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a pulse appears.
  always @(negedge clk) begin
    if (if_q.size() > 0 && if_q[0].cyc < cycle) begin
      checks++; errors++;
      $display("FAIL if_rsp missing: expected pulse at cycle %0d, valid stayed low", if_q[0].cyc);
      void'(if_q.pop_front());
    end
    if (if_rsp_valid === 1'b1) begin
      if (if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_rsp unexpected: pulse at cycle %0d data %h", cycle, if_rsp_data);
      end else begin
        if_e = if_q.pop_front();
        check("if_rsp_cycle", 32'(cycle), 32'(if_e.cyc));
        check("if_rsp_data", if_rsp_data, if_e.data);
        check("if_rsp_err", {31'b0, if_rsp_err}, {31'b0, if_e.err});
      end
    end
    if (ls_q.size() > 0 && ls_q[0].cyc < cycle) begin
      checks++; errors++;
      $display("FAIL ls_rsp missing: expected pulse at cycle %0d, valid stayed low", ls_q[0].cyc);
      void'(ls_q.pop_front());
    end
    if (ls_rsp_valid === 1'b1) begin
      if (ls_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ls_rsp unexpected: pulse at cycle %0d data %h", cycle, ls_rsp_data);
      end else begin
        ls_e = ls_q.pop_front();
        check("ls_rsp_cycle", 32'(cycle), 32'(ls_e.cyc));
        check("ls_rsp_data", ls_rsp_data, ls_e.data);
        check("ls_rsp_err", {31'b0, ls_rsp_err}, {31'b0, ls_e.err});
      end
    end
  end

  // One request cycle: drive, check grants at negedge, queue expected responses.
  task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] id, input logic ie,
                     input logic lv, input logic [31:0] la, input logic lw, input logic [31:0] lwd,
                     input logic [31:0] ld, input logic le,
                     input logic irdy, input logic lrdy, input logic mwe);
    if_req_valid = iv; if_req_addr = ia;
    ls_req_valid = lv; ls_req_addr = la; ls_req_we = lw; ls_req_wdata = lwd;
    @(negedge clk);
    check("if_req_ready", {31'b0, if_req_ready}, {31'b0, irdy});
    check("ls_req_ready", {31'b0, ls_req_ready}, {31'b0, lrdy});
    check("mem_write_enable", {31'b0, mem_write_enable}, {31'b0, mwe});
    if (irdy) if_q.push_back('{data: id, err: ie, cyc: cycle + 1});
    if (lrdy) ls_q.push_back('{data: ld, err: le, cyc: cycle + 1});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_mem_address", mem_address, 32'h0);
    check("idle_mem_write_data", mem_write_data, 32'h0);
  endtask

  task automatic ls_wr(input logic [31:0] a, input logic [31:0] d, input logic err);
    cyc(0, 0, 0, 0, 1, a, 1, d, 0, err, 0, 1, !err);
  endtask

  task automatic ls_rd(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 0, 0, 0, 1, a, 0, 32'h0, d, 0, 0, 1, 0);
  endtask

  task automatic if_rd(input logic [31:0] a, input logic [31:0] d, input logic err);
    cyc(1, a, d, err, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with both requesters active.
    rst_en = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    ls_req_valid = 1'b1; ls_req_addr = 32'h8; ls_req_we = 1'b1; ls_req_wdata = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk);
      check("rst_if_ready", {31'b0, if_req_ready}, 32'h0);
      check("rst_ls_ready", {31'b0, ls_req_ready}, 32'h0);
      check("rst_mem_we", {31'b0, mem_write_enable}, 32'h0);
      check("rst_if_rsp_valid", {31'b0, if_rsp_valid}, 32'h0);
      check("rst_ls_rsp_valid", {31'b0, ls_rsp_valid}, 32'h0);
      check("rst_if_rsp_data", if_rsp_data, 32'h0);
    end
    @(posedge clk); #1;
    rst_en = 1'b0;

    // First grant after reset goes to LS (write), IF then reads the new word.
    cyc(1, 32'h8, 0, 0, 1, 32'h8, 1, 32'hDEADBEEF, 32'h0, 0, 0, 1, 1);
    if_rd(32'h8, 32'hDEADBEEF, 0);
    idle();

    // Contention: four LS grants, then IF, repeated to show the counter restarts.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4)
        cyc(1, 32'h8, 32'hDEADBEEF, 0, 1, 32'h8, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
      else
        cyc(1, 32'h8, 32'hDEADBEEF, 0, 1, 32'h8, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0);
    end
    ls_rd(32'h8, 32'hDEADBEEF);
    idle();

    // Illegal accesses are accepted with an error and leave memory untouched.
    ls_wr(32'h4, 32'h0000_4444, 0);
    ls_wr(32'h0, 32'h0000_A5A5, 0);
    ls_wr(32'h6, 32'h1111_1111, 1);
    ls_wr(32'h100, 32'h2222_2222, 1);
    if_rd(32'h102, 32'h0, 1);
    ls_rd(32'h4, 32'h0000_4444);
    ls_rd(32'h0, 32'h0000_A5A5);
    idle();

    // Burst: fill every word, then IF reads back with back-to-back pulses.
    for (int i = 0; i < 64; i++) ls_wr(32'(i) << 2, 32'(i * 100), 0);
    for (int i = 0; i < 64; i++) if_rd(32'(i) << 2, 32'(i * 100), 0);
    idle();

    // Reset in the cycle after an IF grant drops that response.
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    ls_req_valid = 1'b0; ls_req_we = 1'b0;
    @(negedge clk);
    check("pre_rst_if_ready", {31'b0, if_req_ready}, 32'h1);
    @(posedge clk); #1;
    rst_en = 1'b1; if_req_valid = 1'b0;
    @(negedge clk);
    check("drop_if_rsp_valid_a", {31'b0, if_rsp_valid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_if_rsp_valid_b", {31'b0, if_rsp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_en = 1'b0;
    if_rd(32'h8, 32'd200, 0);
    ls_rd(32'h4, 32'd100);
    idle();
    idle();

    check("if_q_empty", 32'(if_q.size()), 32'h0);
    check("ls_q_empty", 32'(ls_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port word memory (sync write, combinational read) between the instruction-fetch port (IF) and the load/store port (LS).
- Each cycle it grants at most one request, drives the memory, and returns a registered response one cycle later.
- LS has priority; a wait counter prevents IF starvation.
- Misaligned and out-of-range accesses are rejected with an error response and never reach the memory.

Parameters:
DATA_WIDTH, 32, data width of all data buses
WORDS, 64, memory depth in words; legal byte addresses are 0 to WORDS*4-4
MAX_WAIT, 4, consecutive IF stall cycles after which IF wins arbitration (range 1..15)

Ports:
clk  in  1  clock
rst_en  in  1  reset, synchronous, active-high
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted this cycle
if_req_addr  in  32  IF byte address
if_rsp_valid  out  1  IF response pulse
if_rsp_data  out  DATA_WIDTH  IF read data
if_rsp_err  out  1  IF access error
ls_req_valid  in  1  LS request
ls_req_ready  out  1  LS request accepted this cycle
ls_req_addr  in  32  LS byte address
ls_req_we  in  1  LS write (1) / read (0)
ls_req_wdata  in  DATA_WIDTH  LS write data
ls_rsp_valid  out  1  LS response pulse
ls_rsp_data  out  DATA_WIDTH  LS read data (0 for writes)
ls_rsp_err  out  1  LS access error
mem_write_enable  out  1  to memory write_enable
mem_address  out  32  to memory address
mem_write_data  out  DATA_WIDTH  to memory write_data
mem_read_data  in  DATA_WIDTH  from memory read_data

Behaviour:
- Handshake: a request is accepted when valid && ready, in the same cycle.
  - Ready is combinational from the valids and the priority state.
  - At most one ready is high per cycle; ready is never high without valid.
  - Requesters hold addr/we/wdata stable while valid && !ready.
- Priority state (1-bit FSM):
  - LS_PRIO: LS wins when both are valid.
  - IF_PRIO: entered when wait_cnt == MAX_WAIT; IF wins when both are valid.
  - Returns to LS_PRIO on the cycle after an IF handshake.
  - A lone valid requester is always granted in either state.
- wait_cnt (4-bit):
  - Increments when if_req_valid && !if_req_ready; saturates at MAX_WAIT.
  - Clears on an IF handshake, or when if_req_valid is low.
- Memory drive (combinational, granted cycle only):
  - mem_address = granted addr.
  - mem_write_enable = ls_we of the grant && access legal; a write commits at the closing posedge.
  - mem_write_data = ls_req_wdata.
  - Idle cycles drive 0 on all three memory outputs.
- Legality:
  - Error if addr[1:0] != 0 or addr >= WORDS*4.
  - An illegal access is still accepted (ready high), but mem_write_enable stays 0.
  - Response: err=1, data=0.
- Response timing:
  - On the posedge closing the handshake, mem_read_data (reads) or 0 (writes/errors) and err are registered.
  - rsp_valid is high for exactly one cycle, in the cycle after acceptance.
  - Latency is 1 cycle; there is no response backpressure.
  - Back-to-back grants give back-to-back response pulses.
  - Data and err hold their last values while rsp_valid = 0.
- Same-address read-after-write: an IF read granted in the cycle after an LS write returns the new data.
- Reset (rst_en = 1 at posedge):
  - All rsp_valid, rsp_data, rsp_err = 0; wait_cnt = 0; state = LS_PRIO.
  - A response pending from the pre-reset cycle is dropped.
  - While rst_en is high, both readys are 0 and mem_write_enable is 0.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef mem_req_t {addr, we, wdata};
  - typedef mem_rsp_t {valid, data, err};
  - enum arb_state_t {LS_PRIO, IF_PRIO};
  - constant ADDR_LSB = 2.
- One sub-module, mem_arb_rsp_reg: per-port response register with the one-cycle valid pulse, instantiated twice.
- Arbitration and legality check stay in the top module.

Test Plan:
1. Reset: hold rst_en=1 for 2 cycles with both valids high -> readys 0, mem_write_enable 0, rsp_valid 0; release -> first grant goes to LS.
2. LS write 32'hDEADBEEF @0x8, then IF read @0x8 the next cycle -> ls_rsp_valid pulse with data 0; if_rsp_data = 32'hDEADBEEF one cycle after the IF grant, err 0.
3. Both valid continuously (MAX_WAIT=4) -> LS granted 4 cycles, IF granted on cycle 5, then LS resumes; wait_cnt returns to 0.
4. LS write @0x6 (misaligned) and @0x100 (out of range) -> accepted, ls_rsp_err=1, data 0; a read of 0x4 afterwards is unchanged.
5. Burst: LS writes i*100 to addresses i<<2 for i=0..63, then IF reads all -> 64 consecutive if_rsp_valid pulses with matching data.
6. Assert rst_en in the cycle after an IF grant -> no if_rsp_valid pulse appears; the memory content written before reset is preserved.
